hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RISC-V core. It detects load-use hazards and stalls IF/ID for one cycle. It squashes the three younger instructions when the MEM stage redirects the PC, and produces EX-stage operand-forwarding selects from a private shadow of the ID/EX source-register fields. It also keeps stall and flush event counters for performance analysis.

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the five-stage RISC-V pipeline. It detects load-use
// hazards and stalls PC and IF/ID for one cycle while a bubble enters ID/EX.
// It squashes the three younger instructions when the MEM stage redirects the
// PC. It selects EX-stage operand forwarding from a private shadow of the
// ID/EX source-register fields. It also counts stall cycles and redirect events.
//
// Ports
//   clk           core clock, all state updates on the rising edge
//   rst           synchronous active-low reset
//   id_rs1/rs2    source register fields of the instruction in ID
//   id_useRs1/2   ID instruction actually reads rs1 / rs2
//   ex_rd         EX destination register
//   ex_writeReg   EX writes a register
//   ex_readMem    EX read-memory code; nonzero means load
//   me_rd         MEM destination register
//   me_writeReg   MEM writes a register
//   me_readMem    MEM read-memory code; nonzero means load
//   wb_rd         WB destination register
//   wb_writeReg   WB writes a register
//   me_redirect   next_pc is a branch/jump target rather than pc+4
//   pc_hold       PC keeps its value
//   if_id_hold    IF/ID keeps its contents
//   if_id_flush   IF/ID loads a NOP bubble
//   id_ex_flush   ID/EX loads all-zero controls
//   ex_me_flush   EX/ME loads all-zero controls
//   fwdA / fwdB   EX operand source: 00 register file, 01 MEM ALU, 10 WB data
//   stall_cnt     number of load-use stall cycles (wraps)
//   flush_cnt     number of redirect events (wraps)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_writeReg,
  input  logic [2:0]       ex_readMem,
  input  logic [4:0]       me_rd,
  input  logic             me_writeReg,
  input  logic [2:0]       me_readMem,
  input  logic [4:0]       wb_rd,
  input  logic             wb_writeReg,
  input  logic             me_redirect,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_me_flush,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Shadow of the ID/EX source fields; a cleared shadow never forwards.
  logic [4:0]       ex_rs1_q, ex_rs1_d;
  logic [4:0]       ex_rs2_q, ex_rs2_d;
  logic             ex_use1_q, ex_use1_d;
  logic             ex_use2_q, ex_use2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall;
  logic redirect;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign load_use = (ex_readMem != 3'd0) && ex_writeReg && (ex_rd != 5'd0) &&
                    ((id_useRs1 && (id_rs1 == ex_rd)) ||
                     (id_useRs2 && (id_rs2 == ex_rd)));

  // While in reset, nothing is stalled or flushed. A redirect wins over a
  // load-use stall because the stalled instruction is squashed anyway.
  assign redirect = rst && me_redirect;
  assign stall    = rst && !me_redirect && load_use;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
    end else if (stall) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding. MEM holds the younger result and wins over WB. A load in MEM
  // has no data yet, so it never forwards. x0 is never forwarded.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic src_used, input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_used && me_writeReg && (me_readMem == 3'd0) &&
        (me_rd != 5'd0) && (me_rd == src)) begin
      sel = FWD_MEM;
    end else if (src_used && wb_writeReg && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign fwdA = fwd_sel(ex_use1_q, ex_rs1_q);
  assign fwdB = fwd_sel(ex_use2_q, ex_rs2_q);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_rs1_d    = id_rs1;
    ex_rs2_d    = id_rs2;
    ex_use1_d   = id_useRs1;
    ex_use2_d   = id_useRs2;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    // The shadow follows ID/EX, so a bubble entering ID/EX clears it too.
    if (id_ex_flush) begin
      ex_rs1_d  = 5'd0;
      ex_rs2_d  = 5'd0;
      ex_use1_d = 1'b0;
      ex_use2_d = 1'b0;
    end
    if (stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_use1_q   <= ex_use1_d;
      ex_use2_q   <= ex_use2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
